// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin hold arbiter.
package arb_pkg;

  localparam int unsigned MAX_N = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [MAX_N-1:0] onehot(input int unsigned idx);
    return MAX_N'(1) << idx;
  endfunction

  // Increment with explicit wrap so non-power-of-two N never reaches index N.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first set bit of vec at or after ptr, with wrap.
module rr_pick #(
  parameter int unsigned N = 4,
  localparam int unsigned IDXW = $clog2(N)
) (
  input  logic [N-1:0]    vec,
  input  logic [IDXW-1:0] ptr,
  output logic [IDXW-1:0] idx,
  output logic            found
);

  logic [N-1:0]   mask;
  logic [2*N-1:0] dbl;

  // Lower half holds only bits at/after ptr; upper half supplies the wrapped bits.
  always_comb begin
    mask  = {N{1'b1}} << ptr;
    dbl   = {vec, vec & mask};
    idx   = '0;
    found = 1'b0;
    for (int i = 2 * N - 1; i >= 0; i--) begin
      if (dbl[i]) begin
        found = 1'b1;
        idx   = (i >= int'(N)) ? IDXW'(i - int'(N)) : IDXW'(i);
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_hold.sv
// Round-robin arbiter with grant held across a multi-cycle transaction.
module rr_arbiter_hold
  import arb_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 8,
  localparam int unsigned IDXW    = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic            last,
  output logic [N-1:0]    grant,
  output logic [IDXW-1:0] grant_idx,
  output logic            grant_valid
);

  localparam int unsigned CNTW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNTW-1:0] HOLD_LAST = CNTW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  state_t            state_q, state_d;
  logic [N-1:0]      grant_d;
  logic [IDXW-1:0]   idx_d;
  logic              valid_d;
  logic [IDXW-1:0]   ptr, ptr_d;
  logic [CNTW-1:0]   hold_cnt, hold_d;

  logic [N-1:0]      pick_vec;
  logic [IDXW-1:0]   pick_ptr;
  logic [IDXW-1:0]   pick_idx;
  logic              pick_found;

  logic              holder_req;
  logic              hold_expired;
  logic              release_now;
  logic [IDXW-1:0]   next_ptr;

  rr_pick #(.N(N)) u_pick (
    .vec   (pick_vec),
    .ptr   (pick_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign holder_req   = |(req & grant);
  assign hold_expired = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
  assign release_now  = !holder_req || last || hold_expired;
  assign next_ptr     = IDXW'(wrap_inc(32'(grant_idx), N));

  always_comb begin
    state_d  = state_q;
    grant_d  = grant;
    idx_d    = grant_idx;
    valid_d  = grant_valid;
    ptr_d    = ptr;
    hold_d   = hold_cnt;
    pick_vec = req;
    pick_ptr = ptr;

    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = GRANT;
          grant_d = N'(onehot(32'(pick_idx)));
          idx_d   = pick_idx;
          valid_d = 1'b1;
          hold_d  = '0;
        end
      end

      GRANT: begin
        // Holder still requesting stays eligible, but at lowest priority.
        pick_vec = holder_req ? req : (req & ~grant);
        pick_ptr = next_ptr;
        if (release_now) begin
          ptr_d  = next_ptr;
          hold_d = '0;
          if (pick_found) begin
            grant_d = N'(onehot(32'(pick_idx)));
            idx_d   = pick_idx;
            valid_d = 1'b1;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            idx_d   = '0;
            valid_d = 1'b0;
          end
        end else if (!(&hold_cnt)) begin
          hold_d = CNTW'(hold_cnt + 1'b1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      ptr         <= '0;
      hold_cnt    <= '0;
    end else begin
      state_q     <= state_d;
      grant       <= grant_d;
      grant_idx   <= idx_d;
      grant_valid <= valid_d;
      ptr         <= ptr_d;
      hold_cnt    <= hold_d;
    end
  end

endmodule

// File: tb/tb_rr_arbiter_hold.sv
// Scoreboard bench for rr_arbiter_hold: N=4/MAX_HOLD=4 and N=3/MAX_HOLD=0 instances.
module tb_rr_arbiter_hold;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req4;
  logic       last4;
  logic [3:0] grant4;
  logic [1:0] idx4;
  logic       valid4;
  logic [2:0] req3;
  logic       last3;
  logic [2:0] grant3;
  logic [1:0] idx3;
  logic       valid3;

  int checks = 0;
  int errors = 0;
  logic [6:0] sb[$];

  always #5 clk = ~clk;

  rr_arbiter_hold #(.N(4), .MAX_HOLD(4)) dut4 (
    .clk(clk), .rst(rst), .req(req4), .last(last4),
    .grant(grant4), .grant_idx(idx4), .grant_valid(valid4)
  );

  rr_arbiter_hold #(.N(3), .MAX_HOLD(0)) dut3 (
    .clk(clk), .rst(rst), .req(req3), .last(last3),
    .grant(grant3), .grant_idx(idx3), .grant_valid(valid3)
  );

  function automatic logic [6:0] exp_word(input logic [3:0] g);
    logic [1:0] ix;
    ix = '0;
    for (int i = 0; i < 4; i++) if (g[i]) ix = 2'(i);
    return {g, ix, |g};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req4 = '0; last4 = 1'b0; req3 = '0; last3 = 1'b0;
    step(); step();
    checks++;
    if ({grant4, idx4, valid4} !== 7'b0) begin
      errors++; $display("FAIL reset_out4 got %b exp %b", {grant4, idx4, valid4}, 7'b0);
    end
    checks++;
    if (dut4.ptr !== 2'd0) begin
      errors++; $display("FAIL reset_ptr4 got %0d exp 0", dut4.ptr);
    end
    checks++;
    if ({grant3, idx3, valid3} !== 6'b0) begin
      errors++; $display("FAIL reset_out3 got %b exp %b", {grant3, idx3, valid3}, 6'b0);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic_order();
    logic [6:0] e;
    req4 = 4'b1111; last4 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      sb.push_back(exp_word(4'(4'b0001 << ((i / 4) % 4))));
      step();
      e = sb.pop_front();
      checks++;
      if ({grant4, idx4, valid4} !== e) begin
        errors++; $display("FAIL basic_order cyc %0d got %b exp %b", i, {grant4, idx4, valid4}, e);
      end
    end
    sb.push_back(exp_word(4'b0000));
    req4 = 4'b0000;
    step();
    e = sb.pop_front();
    checks++;
    if ({grant4, idx4, valid4} !== e) begin
      errors++; $display("FAIL basic_order_drop got %b exp %b", {grant4, idx4, valid4}, e);
    end
  endtask

  task automatic test_last_release();
    logic       r_rst[7];
    logic [3:0] r_req[7];
    logic       r_last[7];
    logic [3:0] r_exp[7];
    logic [6:0] e;
    r_rst  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    r_req  = '{4'b0000, 4'b0101, 4'b0101, 4'b0101, 4'b0000, 4'b0001, 4'b0000};
    r_last = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    r_exp  = '{4'b0000, 4'b0001, 4'b0001, 4'b0100, 4'b0000, 4'b0001, 4'b0000};
    for (int i = 0; i < 7; i++) begin
      sb.push_back(exp_word(r_exp[i]));
      rst = r_rst[i]; req4 = r_req[i]; last4 = r_last[i];
      step();
      e = sb.pop_front();
      checks++;
      if ({grant4, idx4, valid4} !== e) begin
        errors++; $display("FAIL last_release cyc %0d got %b exp %b", i, {grant4, idx4, valid4}, e);
      end
      if (i == 3) begin
        checks++;
        if (dut4.ptr !== 2'd1) begin
          errors++; $display("FAIL last_release_ptr got %0d exp 1", dut4.ptr);
        end
      end
    end
    last4 = 1'b0;
  endtask

  task automatic test_holder_drops();
    logic [3:0] r_req[4];
    logic [3:0] r_exp[4];
    logic [6:0] e;
    r_req = '{4'b0010, 4'b0000, 4'b1001, 4'b0000};
    r_exp = '{4'b0010, 4'b0000, 4'b1000, 4'b0000};
    for (int i = 0; i < 4; i++) begin
      sb.push_back(exp_word(r_exp[i]));
      req4 = r_req[i];
      step();
      e = sb.pop_front();
      checks++;
      if ({grant4, idx4, valid4} !== e) begin
        errors++; $display("FAIL holder_drops cyc %0d got %b exp %b", i, {grant4, idx4, valid4}, e);
      end
    end
  endtask

  task automatic test_sole_timeout();
    logic [6:0] e;
    req4 = 4'b0100;
    for (int i = 0; i < 9; i++) begin
      sb.push_back(exp_word(4'b0100));
      step();
      e = sb.pop_front();
      checks++;
      if ({grant4, idx4, valid4} !== e) begin
        errors++; $display("FAIL sole_timeout cyc %0d got %b exp %b", i, {grant4, idx4, valid4}, e);
      end
      checks++;
      if (32'(dut4.hold_cnt) !== i % 4) begin
        errors++; $display("FAIL sole_hold_cnt cyc %0d got %0d exp %0d", i, dut4.hold_cnt, i % 4);
      end
      if (i == 4) begin
        checks++;
        if (dut4.ptr !== 2'd3) begin
          errors++; $display("FAIL sole_ptr got %0d exp 3", dut4.ptr);
        end
      end
    end
    sb.push_back(exp_word(4'b0000));
    req4 = 4'b0000;
    step();
    e = sb.pop_front();
    checks++;
    if ({grant4, idx4, valid4} !== e) begin
      errors++; $display("FAIL sole_release got %b exp %b", {grant4, idx4, valid4}, e);
    end
  endtask

  task automatic test_reset_mid_grant();
    logic       r_rst[6];
    logic [3:0] r_req[6];
    logic [3:0] r_exp[6];
    logic [6:0] e;
    r_rst = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    r_req = '{4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b1010, 4'b0000};
    r_exp = '{4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0010, 4'b0000};
    for (int i = 0; i < 6; i++) begin
      sb.push_back(exp_word(r_exp[i]));
      rst = r_rst[i]; req4 = r_req[i];
      step();
      e = sb.pop_front();
      checks++;
      if ({grant4, idx4, valid4} !== e) begin
        errors++; $display("FAIL reset_mid cyc %0d got %b exp %b", i, {grant4, idx4, valid4}, e);
      end
      if (i == 2) begin
        checks++;
        if (dut4.ptr !== 2'd0) begin
          errors++; $display("FAIL reset_mid_ptr got %0d exp 0", dut4.ptr);
        end
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_npot();
    logic [2:0] r_req[17];
    logic       r_last[17];
    logic [2:0] r_exp[17];
    logic [6:0] e;
    for (int i = 0; i < 17; i++) begin
      if (i < 4) begin
        r_req[i] = 3'b111; r_last[i] = 1'b1; r_exp[i] = 3'(3'b001 << (i % 3));
      end else if (i == 4 || i == 16) begin
        r_req[i] = 3'b000; r_last[i] = 1'b0; r_exp[i] = 3'b000;
      end else begin
        r_req[i] = 3'b010; r_last[i] = 1'b0; r_exp[i] = 3'b010;
      end
    end
    for (int i = 0; i < 17; i++) begin
      sb.push_back(exp_word({1'b0, r_exp[i]}));
      req3 = r_req[i]; last3 = r_last[i];
      step();
      e = sb.pop_front();
      checks++;
      if ({1'b0, grant3, idx3, valid3} !== e) begin
        errors++; $display("FAIL npot cyc %0d got %b exp %b", i, {1'b0, grant3, idx3, valid3}, e);
      end
    end
    last3 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_order();
    test_last_release();
    test_holder_drops();
    test_sole_timeout();
    test_reset_mid_grant();
    test_npot();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_hold.md
Name: rr_arbiter_hold

Overview:
- Parametrised round-robin arbiter for N requesters with a registered one-hot grant.
- Grant is held for a multi-cycle transaction; it is released by the holder dropping `req`, by a `last` pulse, or by a burst-limit timeout.
- On release, re-arbitration is back-to-back with no idle bubble.
- Sits in front of a shared resource (bus or memory port) and replaces the fixed 4-channel arbiter.

Parameters:
- N, 4, number of requesters (2..32).
- MAX_HOLD, 8, max consecutive grant cycles per tenure; 0 = unlimited.
- IDXW, $clog2(N), width of `grant_idx` (derived; not overridden).

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- req  in  N  request vector; bit i = requester i wants the resource.
- last  in  1  asserted by the current holder on its final transfer cycle.
- grant  out  N  one-hot registered grant; all-zero when idle.
- grant_idx  out  IDXW  binary index of the granted requester; 0 when idle.
- grant_valid  out  1  high when any grant bit is set.

Behaviour:
- Reset values: `grant`=0, `grant_idx`=0, `grant_valid`=0, `ptr`=0, `hold_cnt`=0, state=IDLE. Reset takes effect at the next edge regardless of state; a grant active during reset is dropped at that edge.
- `ptr` (IDXW bits) is the highest-priority index. Priority order is ptr, ptr+1, …, N-1, 0, …, ptr-1 (mod N).
- `pick(vec, ptr)` is combinational: returns the first set bit of `vec` at or after `ptr` with wrap, plus a found flag.
- State IDLE:
  - If `req`≠0, go to GRANT at the next edge.
  - Set `grant`=onehot(pick(req,ptr)) and `hold_cnt`=0.
  - Latency: `req` seen at edge k → grant visible after edge k+1 (1 cycle).
- State GRANT, holder g: release condition R = !req[g] | last | (MAX_HOLD≠0 & hold_cnt==MAX_HOLD-1).
- GRANT, R=0: keep `grant`; increment `hold_cnt`. The counter width holds MAX_HOLD-1 and never wraps.
- GRANT, R=1, in the same edge:
  - Set `ptr`=(g+1) mod N.
  - Let c = req & ~(onehot(g) if !req[g]).
  - If c≠0: grant pick(c, (g+1) mod N) immediately (back-to-back), `hold_cnt`=0, stay in GRANT.
  - If c=0: `grant`=0, go to IDLE.
- The previous holder is lowest priority at release. If it is the only requester and still asserts `req` (timeout, or `last` with `req` still high), it is re-granted and `hold_cnt` restarts at 0.
- `last` is ignored in IDLE.
- `req` changes on non-holder bits never pre-empt the current grant.
- `grant` is never multi-hot; `grant_valid` = |grant; `grant_idx` is always consistent with `grant`. All three are registered, with no combinational path from `req` to outputs.
- N not a power of two: the pointer increment wraps explicitly at N-1 → 0.
- Starvation bound: any asserted `req` is granted within (N-1)·MAX_HOLD + N cycles when MAX_HOLD≠0.

Decomposition:
- Package `arb_pkg`:
  - state enum {IDLE, GRANT};
  - function `onehot(idx)`;
  - function `wrap_inc(idx, N)`.
- Sub-module `rr_pick` (param N): combinational rotate-priority encoder, inputs vec and ptr, outputs idx and found.
  - Implemented as a double-width masked priority encoder.
  - Instantiated once in `rr_arbiter_hold`.

Test Plan:
- Basic order (N=4, MAX_HOLD=4):
  - Stimulus: `req`=1111 held, `last`=0.
  - Required: grants 0001 ×4 cycles, 0010 ×4, 0100 ×4, 1000 ×4, 0001 ×4; no bubble cycles; `grant_idx` 0,1,2,3,0.
- Last-driven release:
  - Stimulus: `req`=0101, `last` pulsed on the 2nd grant cycle.
  - Required: grant 0001 for 2 cycles, then 0100 the next cycle.
  - `ptr` moves past 0; a later `req`=0001 alone is still granted.
- Holder drops req:
  - Stimulus: grant=0010, then `req` goes 0010→0000.
  - Required: `grant`=0000 and `grant_valid`=0 at the next edge.
  - Then `req`=1001 → grant 1000 (ptr=2 gives index 3 before 0).
- Sole requester timeout:
  - Stimulus: `req`=0100 held, MAX_HOLD=4.
  - Required: grant stays 0100 continuously, `hold_cnt` cycles 0..3 then restarts, `ptr`=3 after the first expiry.
- Reset mid-grant:
  - Stimulus: assert `rst` one cycle while grant=1000.
  - Required: next edge gives `grant`=0, `grant_idx`=0, `ptr`=0.
  - After release, `req`=1010 → grant 0010 first.
- Non-power-of-two (N=3, MAX_HOLD=0):
  - Stimulus: `req`=111 with `last` pulsed every cycle.
  - Required: grant sequence 001, 010, 100, 001; `grant_idx` never reaches 3.
